// File: rtl/adc_frame_sampler_if.sv
// adc_frame_sampler_if: ADC handshake, imager strobe and sample-FIFO signals for the frame sampler
interface adc_frame_sampler_if;
  logic       frameStart;
  logic       startCapture;
  logic       conversionComplete;
  logic [7:0] adcData;
  logic       pixelAdvance;
  logic       rdEn;
  logic [7:0] rdData;
  logic       fifoEmpty;
  logic       fifoFull;
  logic       busy;
  logic       frameDone;
  logic       overflow;
  logic       timeoutErr;
  modport master (
    input  frameStart, conversionComplete, adcData, rdEn,
    output startCapture, pixelAdvance, rdData, fifoEmpty, fifoFull, busy, frameDone, overflow, timeoutErr
  );
  modport slave (
    output frameStart, conversionComplete, adcData, rdEn,
    input  startCapture, pixelAdvance, rdData, fifoEmpty, fifoFull, busy, frameDone, overflow, timeoutErr
  );
endinterface

// File: rtl/adc_frame_sampler.sv
// adc_frame_sampler: per-frame ADC sequencer with show-ahead sample FIFO; optional watchdog via ADC_FRAME_SAMPLER_TIMEOUT_EN
module adc_frame_sampler #(
  parameter int NUM_PIXELS     = 256,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 reset,
  adc_frame_sampler_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, REQ, ACK, ADV, DONE} state_t;
  state_t        state_q, state_d;
  logic          fs_q, cc_q;
  logic [7:0]    adc_q;
  logic [15:0]   cnt_q, cnt_d;
  logic          start_q, start_d, adv_q, adv_d, done_q, done_d, busy_q, busy_d;
  logic          ovf_q, ovf_d, terr_q, terr_d;
  logic          last, arm, wr_req, wr, rd, tmo_hit;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]   occ_q, occ_d;
  logic [7:0]    rd_q, rd_d;
  logic          empty_q, full_q;

  assign last   = cnt_q == 16'(NUM_PIXELS - 1);
  assign arm    = state_q == IDLE && fs_q;
  assign wr_req = state_q == REQ && !cc_q;
  assign wr     = wr_req && !full_q;
  assign rd     = bus.rdEn && !empty_q;
  assign rd_nxt = rd_ptr_q + AW'(1);

  // capture the driver-side inputs once so the FSM works from registered copies
  always_ff @(posedge clk) begin
    if (!reset) begin
      fs_q  <= 1'b0;
      cc_q  <= 1'b1;
      adc_q <= '0;
    end else begin
      fs_q  <= bus.frameStart;
      cc_q  <= bus.conversionComplete;
      adc_q <= bus.adcData;
    end
  end

`ifdef ADC_FRAME_SAMPLER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          waiting;
  assign waiting = state_q == REQ || state_q == ACK;
  assign tmo_hit = waiting && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  // watchdog counts cycles spent in the current REQ or ACK visit
  always_ff @(posedge clk) begin
    tmo_q <= (!reset || !waiting || state_d != state_q) ? '0 : tmo_q + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // state register together with the registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b1;
      adv_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      adv_q   <= adv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      terr_q  <= terr_d;
    end
  end

  // next state: an ack wins over a watchdog expiry landing on the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fs_q ? REQ : IDLE;
      REQ:     state_d = !cc_q ? ACK : tmo_hit ? DONE : REQ;
      ACK:     state_d = cc_q ? ADV : tmo_hit ? DONE : ACK;
      ADV:     state_d = last ? DONE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output values for the cycle after the transition; startCapture is low exactly while in REQ
  always_comb begin
    start_d = state_d != REQ;
    adv_d   = state_q == ADV;
    done_d  = state_q == DONE;
    busy_d  = state_d != IDLE;
    cnt_d   = arm ? '0 : (state_q == ADV && !last) ? cnt_q + 16'd1 : cnt_q;
    ovf_d   = arm ? 1'b0 : ovf_q | (wr_req & full_q);
    terr_d  = arm ? 1'b0 : terr_q | ((state_q == REQ || state_q == ACK) && state_d == DONE);
  end

  // FIFO occupancy and the show-ahead head value after this cycle's push/pop
  always_comb begin
    occ_d = occ_q + (AW+1)'(wr) - (AW+1)'(rd);
    rd_d  = rd ? (occ_q > (AW+1)'(1) ? mem[rd_nxt] : wr ? adc_q : rd_q) : (empty_q && wr) ? adc_q : rd_q;
  end

  // FIFO pointers and flags; full is judged before the pop so a full-cycle write is dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rd_q     <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_nxt;
      occ_q   <= occ_d;
      rd_q    <= rd_d;
      empty_q <= occ_d == '0;
      full_q  <= occ_d == (AW+1)'(FIFO_DEPTH);
    end
  end

  // sample storage; stale entries are unreachable once occupancy resets
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= adc_q;
  end

  assign bus.startCapture = start_q;
  assign bus.pixelAdvance = adv_q;
  assign bus.frameDone    = done_q;
  assign bus.busy         = busy_q;
  assign bus.overflow     = ovf_q;
  assign bus.timeoutErr   = terr_q;
  assign bus.rdData       = rd_q;
  assign bus.fifoEmpty    = empty_q;
  assign bus.fifoFull     = full_q;
endmodule
